// File: rtl/fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_ctrl_pkg;

    // Fetch sequencer states; 3-bit encoding so ERR fits beside the four working states.
    typedef enum logic [2:0] {
        FETCH_IDLE = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        FETCH_HOLD = 3'd3,
        FETCH_ERR  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    // Sequential PC step; wraps modulo 2^32 so 32'hFFFF_FFFC rolls to 0.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // A fetch target must be word aligned.
    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// WAIT-state watchdog: counts cycles spent waiting for read data and
// flags the cycle on which the wait budget is used up.
module fetch_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q;

    // Clear on grant, count every cycle while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th waiting cycle (counter started at 0 on grant).
    assign timeout = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs one request/grant/rvalid
// transaction at a time and presents each word to decode from a one-entry
// output register.
//
// Handshake: the memory accepts an address only on a cycle with
// imem_req && imem_gnt; exactly one imem_rvalid follows, at least one cycle
// later. Decode takes if_inst on any cycle with if_valid && !id_stall.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redir_ce,
    input  logic [31:0] redir_addr,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        fetch_err,
    output logic [2:0]  dbg_state
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         kill_q;
    logic         wd_timeout;

    assign imem_req  = (state_q == FETCH_REQ);
    assign imem_addr = pc_q;
    assign dbg_state = state_q;

    fetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state_q == FETCH_REQ) && imem_gnt),
        .en      (state_q == FETCH_WAIT),
        .timeout (wd_timeout)
    );

    // Fetch FSM with registered decode-side outputs; redirect outranks everything except ERR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            if_valid  <= 1'b0;
            if_inst   <= ZERO;
            if_pc     <= ZERO;
            fetch_err <= 1'b0;
        end else if (state_q != FETCH_ERR && redir_ce) begin
            if_valid <= 1'b0;
            if (misaligned(redir_addr)) begin
                fetch_err <= 1'b1;
                state_q   <= FETCH_ERR;
            end else begin
                pc_q <= redir_addr;
                case (state_q)
                    FETCH_REQ: begin
                        // A same-cycle grant launched the old address; its data must be dropped.
                        if (imem_gnt) begin
                            state_q <= FETCH_WAIT;
                            kill_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH_REQ;
                        end
                    end
                    FETCH_WAIT: begin
                        if (imem_rvalid) begin
                            state_q <= FETCH_REQ;
                            kill_q  <= 1'b0;
                        end else begin
                            kill_q  <= 1'b1;
                        end
                    end
                    default: state_q <= FETCH_REQ;
                endcase
            end
        end else begin
            case (state_q)
                FETCH_IDLE: state_q <= FETCH_REQ;
                FETCH_REQ: begin
                    if (imem_gnt) state_q <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= FETCH_REQ;
                        end else begin
                            if_inst  <= imem_rdata;
                            if_pc    <= pc_q;
                            if_valid <= 1'b1;
                            pc_q     <= pc_step(pc_q);
                            state_q  <= FETCH_HOLD;
                        end
                    end else if (wd_timeout) begin
                        fetch_err <= 1'b1;
                        state_q   <= FETCH_ERR;
                    end
                end
                FETCH_HOLD: begin
                    if (!id_stall) begin
                        if_valid <= 1'b0;
                        state_q  <= FETCH_REQ;
                    end
                end
                FETCH_ERR: begin
                    if_valid  <= 1'b0;
                    fetch_err <= 1'b1;
                end
                default: state_q <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, stall, redirects,
// misaligned redirect, timeout and PC wrap (second instance at a high RESET_PC).
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redir_ce = 1'b0;
    logic [31:0] redir_addr = 32'h0;
    logic        id_stall = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        imem_req, if_valid, fetch_err;
    logic [31:0] imem_addr, if_inst, if_pc;
    logic [2:0]  dbg_state;

    logic        hi_imem_req, hi_if_valid, hi_fetch_err;
    logic [31:0] hi_imem_addr, hi_if_inst, hi_if_pc;
    logic [2:0]  hi_dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Clock and DUTs
    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .redir_ce(redir_ce), .redir_addr(redir_addr),
        .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .fetch_err(fetch_err), .dbg_state(dbg_state)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) u_dut_hi (
        .clk(clk), .rst(rst), .redir_ce(redir_ce), .redir_addr(redir_addr),
        .id_stall(id_stall), .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(hi_if_valid), .if_inst(hi_if_inst), .if_pc(hi_if_pc),
        .fetch_err(hi_fetch_err), .dbg_state(hi_dbg_state)
    );

    // Advance one clock; observe/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: grant the pending request, then return data one cycle later; ends in HOLD.
    task automatic serve(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
        n_cmp++; if (hi_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_hi_addr: got %h expected fffffffc", hi_imem_addr); end
        n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if: got v=%b inst=%h pc=%h expected 0/0/0", if_valid, if_inst, if_pc); end
        n_cmp++; if (fetch_err !== 1'b0 || dbg_state !== FETCH_IDLE) begin n_fail++; $display("FAIL rst_state: got err=%b st=%0d expected 0/IDLE", fetch_err, dbg_state); end
        rst = 1'b1;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || dbg_state !== FETCH_REQ) begin n_fail++; $display("FAIL rst_first_req: got req=%b st=%0d expected 1/REQ", imem_req, dbg_state); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] data;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            data = 32'hA000_0000 + 32'(i);
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin n_fail++; $display("FAIL stream_req%0d: got req=%b addr=%h expected 1/%h", i, imem_req, imem_addr, exp_pc); end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            n_cmp++; if (imem_req !== 1'b0 || dbg_state !== FETCH_WAIT) begin n_fail++; $display("FAIL stream_wait%0d: got req=%b st=%0d expected 0/WAIT", i, imem_req, dbg_state); end
            imem_rvalid = 1'b1;
            imem_rdata  = data;
            tick();
            imem_rvalid = 1'b0;
            n_cmp++; if (if_valid !== 1'b1 || if_inst !== data || if_pc !== exp_pc) begin n_fail++; $display("FAIL stream_word%0d: got v=%b inst=%h pc=%h expected 1/%h/%h", i, if_valid, if_inst, if_pc, data, exp_pc); end
            tick();
            n_cmp++; if (if_valid !== 1'b0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL stream_consume%0d: got v=%b err=%b expected 0/0", i, if_valid, fetch_err); end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        // Now in REQ at 0x0C
        serve(32'h1234_5678);
        id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_inst !== 32'h1234_5678 || if_pc !== 32'h0C || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b inst=%h pc=%h req=%b expected 1/12345678/0000000c/0", i, if_valid, if_inst, if_pc, imem_req); end
        end
        id_stall = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h v=%b expected 1/00000010/0", imem_req, imem_addr, if_valid); end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt   = 1'b0;
        redir_ce   = 1'b1;
        redir_addr = 32'h100;
        tick();
        redir_ce = 1'b0;
        n_cmp++; if (dbg_state !== FETCH_WAIT || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_wait_state: got st=%0d addr=%h expected WAIT/00000100", dbg_state, imem_addr); end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_wait_drop: got v=%b req=%b addr=%h expected 0/1/00000100", if_valid, imem_req, imem_addr); end
        serve(32'h5555_0100);
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h5555_0100) begin n_fail++; $display("FAIL redir_wait_first: got v=%b pc=%h inst=%h expected 1/00000100/55550100", if_valid, if_pc, if_inst); end
        tick();
    endtask

    task automatic test_redirect_rvalid_hold();
        // Redirect on the rvalid cycle
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBEEF;
        redir_ce    = 1'b1;
        redir_addr  = 32'h200;
        tick();
        imem_rvalid = 1'b0;
        redir_ce    = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_rv: got v=%b req=%b addr=%h expected 0/1/00000200", if_valid, imem_req, imem_addr); end
        serve(32'hC1C1_0200);
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== 32'hC1C1_0200) begin n_fail++; $display("FAIL redir_rv_nokill: got v=%b pc=%h inst=%h expected 1/00000200/c1c10200", if_valid, if_pc, if_inst); end
        // Redirect while held under stall
        id_stall = 1'b1;
        tick();
        redir_ce   = 1'b1;
        redir_addr = 32'h300;
        tick();
        redir_ce = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL redir_hold: got v=%b req=%b addr=%h expected 0/1/00000300", if_valid, imem_req, imem_addr); end
        id_stall = 1'b0;
        serve(32'h0000_0300);
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h300) begin n_fail++; $display("FAIL redir_hold_first: got v=%b pc=%h expected 1/00000300", if_valid, if_pc); end
        tick();
    endtask

    task automatic test_misaligned();
        redir_ce   = 1'b1;
        redir_addr = 32'h102;
        tick();
        redir_ce = 1'b0;
        n_cmp++; if (fetch_err !== 1'b1 || dbg_state !== FETCH_ERR) begin n_fail++; $display("FAIL misal_err: got err=%b st=%0d expected 1/ERR", fetch_err, dbg_state); end
        imem_gnt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (imem_req !== 1'b0 || fetch_err !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL misal_stuck%0d: got req=%b err=%b v=%b expected 0/1/0", i, imem_req, fetch_err, if_valid); end
        end
        imem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (fetch_err !== 1'b0 || imem_addr !== 32'h0 || dbg_state !== FETCH_IDLE) begin n_fail++; $display("FAIL misal_rst: got err=%b addr=%h st=%0d expected 0/00000000/IDLE", fetch_err, imem_addr, dbg_state); end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL misal_restart: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_timeout();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        repeat (15) tick();
        n_cmp++; if (fetch_err !== 1'b0 || dbg_state !== FETCH_WAIT) begin n_fail++; $display("FAIL tmo_early: got err=%b st=%0d expected 0/WAIT", fetch_err, dbg_state); end
        tick();
        n_cmp++; if (fetch_err !== 1'b1 || dbg_state !== FETCH_ERR || imem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_err: got err=%b st=%0d req=%b expected 1/ERR/0", fetch_err, dbg_state, imem_req); end
    endtask

    task automatic test_wrap();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (hi_imem_req !== 1'b1 || hi_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: got req=%b addr=%h expected 1/fffffffc", hi_imem_req, hi_imem_addr); end
        serve(32'h7777_0001);
        n_cmp++; if (hi_if_valid !== 1'b1 || hi_if_pc !== 32'hFFFF_FFFC || hi_if_inst !== 32'h7777_0001) begin n_fail++; $display("FAIL wrap_word: got v=%b pc=%h inst=%h expected 1/fffffffc/77770001", hi_if_valid, hi_if_pc, hi_if_inst); end
        tick();
        n_cmp++; if (hi_imem_req !== 1'b1 || hi_imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_second: got req=%b addr=%h expected 1/00000000", hi_imem_req, hi_imem_addr); end
        n_cmp++; if (imem_addr !== 32'h4 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL wrap_lo: got addr=%h err=%b expected 00000004/0", imem_addr, fetch_err); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_hold();
        test_misaligned();
        test_timeout();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
